lsu_mem_ctrl: RTL
=================

# lsu_mem_ctrl

Load/store unit that drives the single-port data memory on behalf of the core. It accepts byte, halfword and word loads and stores on a valid/ready request interface. Sub-word and misaligned stores are performed as read-modify-write, because the memory has no byte enables. Accesses that straddle a word boundary are split into two word accesses. It sits between the execute stage and the data memory and owns that memory's Adr/WD/WE/OE/RD port.

## Interface
Parameters:
- `MEM_AW`, default 30, width of the word index driven on `mem_adr`; the remaining upper bits are zero.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: core request present.
- `req_ready` output 1: unit can accept; high only in IDLE.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores use 000/001/010.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, LSB-aligned.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: load result, extended per funct3; 0 for stores and errors.
- `resp_err` output 1: illegal funct3, valid only with `resp_valid`.
- `mem_adr` output 32: word index, `{0, word}`.
- `mem_wd` output 32: memory write data.
- `mem_we` output 1: memory write enable; memory writes on the edge.
- `mem_oe` output 1: memory read enable.
- `mem_rd` input 32: combinational read data from the memory.

## Operation
- Capture on the edge where `req_valid && req_ready`. Captured fields:
  - `w0 = addr[31:2]`
  - `off = addr[1:0]`
  - `size` = 1, 2 or 4 bytes
  - `we`, `funct3`, `wdata`
- `span = (off + size > 4)`. The second word is `w1 = w0 + 1` modulo 2^MEM_AW, so it wraps to 0.
- States:
  - IDLE: if the request is accepted, go to ERR when funct3 is illegal; otherwise go to WR0 for an aligned SW (no read needed); otherwise go to RD0.
  - RD0: `mem_adr = w0`, `mem_oe = 1`, latch `mem_rd` into `buf0`. Next is RD1 if span, else WR0 if store, else RESP.
  - RD1: `mem_adr = w1`, `mem_oe = 1`, latch `mem_rd` into `buf1`. Next is WR0 if store, else RESP.
  - WR0: `mem_adr = w0`, `mem_we = 1`, `mem_wd = merge0`. Next is WR1 if span, else RESP.
  - WR1: `mem_adr = w1`, `mem_we = 1`, `mem_wd = merge1`. Next is RESP.
  - RESP: `resp_valid = 1`, `resp_rdata = extract({buf1, buf0} >> 8*off)`. Next is IDLE.
  - ERR: `resp_valid = 1`, `resp_err = 1`, `resp_rdata = 0`, no memory access. Next is IDLE.
- Store merge: byte lanes `off` through `off+size-1` of the 64-bit `{buf1, buf0}` are replaced with `wdata[8*size-1:0]`. The result is `{merge1, merge0}`.
- Extract: LB/LH sign-extend bit 7 or bit 15. LBU/LHU zero-extend. LW passes the word through.
- Store with an illegal funct3 (011, 1xx) goes to ERR. Nothing is written.
- `mem_wd` is 0 and `mem_adr` is 0 whenever neither `mem_we` nor `mem_oe` is asserted.

## Timing
- Reset (asynchronous, `rst_n` low):
  - state goes to IDLE; `buf0`, `buf1` and captured fields clear to 0.
  - `resp_valid`, `resp_err`, `resp_rdata`, `mem_we`, `mem_oe`, `mem_adr` and `mem_wd` are all 0.
  - `req_ready` is 1.
- Memory-side outputs and response outputs are decoded from registered state and captured fields, so they are glitch-free relative to the core inputs. `req_ready = (state == IDLE)`.
- Latency, counted in cycles from the accept edge to the cycle with `resp_valid` high:
  - aligned load: 2
  - aligned SW: 2
  - aligned SB/SH: 3
  - split load: 3
  - split store: 5
  - illegal funct3: 1
- Back-to-back throughput: a new request can be accepted on the edge that leaves RESP/ERR only if `req_ready` is high. Because `req_ready` is low in RESP, the minimum gap is one idle cycle.
- Reset asserted mid-operation aborts at once and no response is issued. If a split store is aborted after WR0, word `w0` is updated and `w1` is not; this is accepted.
- Request inputs are ignored outside IDLE.

## Structure
- `lsu_pkg` holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the state enum (S_IDLE, S_RD0, S_RD1, S_WR0, S_WR1, S_RESP, S_ERR)
  - a size-decode function
- Sub-module `lsu_align` is combinational and holds the merge and extract datapath. Its inputs are `buf0`, `buf1`, `off`, `funct3` and `wdata`; its outputs are `merge0`, `merge1` and `rdata`. The top-level module keeps the FSM and registers.

## Test plan
- Aligned LW at 0x10, memory word 4 = 0xDEADBEEF: RD0 drives `mem_adr = 4` with `mem_oe = 1`; two cycles after accept, `resp_rdata = 0xDEADBEEF`.
- SB 0xA5 at 0x09 over word 2 = 0x11223344: RD0 then WR0 with `mem_wd = 0x1122A544`. A following LBU at 0x09 returns 0x000000A5 and LB returns 0xFFFFFFA5.
- Split LH at 0x0F, word 3 = 0x80xxxxxx, word 4 = 0xxxxxxx7F: RD0(3), RD1(4), then `resp_rdata = 0x00007F80`.
- Split SW 0xCAFEF00D at 0x0E, words 3 and 4 initially 0: word 3 becomes 0xF00D0000, word 4 becomes 0x0000CAFE; total latency 5.
- LW at 0x0 with funct3 = 011: ERR; `resp_err = 1`, `resp_rdata = 0`; `mem_oe` and `mem_we` never asserted.
- Split SW at word 0x3FFFFFFF, byte offset 2: second access `mem_adr = 0` (wrap). Separately, `rst_n` pulsed low during WR0 of an SB: `mem_we` drops asynchronously, no `resp_valid`, `req_ready = 1`.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// access-size decode and funct3 legality check.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD0,
      S_RD1,
      S_WR0,
      S_WR1,
      S_RESP,
      S_ERR
   } state_t;

   // Access size in bytes (1, 2 or 4); unsigned variants share the low bits.
   function automatic logic [2:0] size_of(input logic [2:0] f3);
      logic [2:0] sz;
      case (f3[1:0])
         2'b00:   sz = 3'd1;
         2'b01:   sz = 3'd2;
         default: sz = 3'd4;
      endcase
      return sz;
   endfunction

   // Stores accept only B/H/W; loads additionally accept BU/HU.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~we;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational byte-lane datapath: merges store data into the two buffered
// words and extracts/extends load data from them.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] buf0,
   input  logic [31:0] buf1,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   output logic [31:0] merge0,
   output logic [31:0] merge1,
   output logic [31:0] rdata
);

   logic [2:0]  w_size;
   logic [7:0]  w_size_mask;
   logic [7:0]  w_lane_mask;
   logic [63:0] w_old;
   logic [63:0] w_wd_shift;
   logic [63:0] w_merged;
   logic [63:0] w_rd_shift;
   logic [31:0] w_rd_word;

   assign w_size = size_of(funct3);
   assign w_old  = {buf1, buf0};

   // Lanes covered by the access, before positioning at the byte offset.
   always_comb begin
      case (w_size)
         3'd1:    w_size_mask = 8'h01;
         3'd2:    w_size_mask = 8'h03;
         default: w_size_mask = 8'h0F;
      endcase
   end

   assign w_lane_mask = w_size_mask << off;
   assign w_wd_shift  = {32'd0, wdata} << {off, 3'b000};

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         assign w_merged[8*gi +: 8] = w_lane_mask[gi] ? w_wd_shift[8*gi +: 8]
                                                       : w_old[8*gi +: 8];
      end
   endgenerate

   assign merge0 = w_merged[31:0];
   assign merge1 = w_merged[63:32];

   assign w_rd_shift = w_old >> {off, 3'b000};
   assign w_rd_word  = w_rd_shift[31:0];

   // Sign- or zero-extend the low bytes of the realigned load word.
   always_comb begin
      case (funct3)
         F3_B:    rdata = {{24{w_rd_word[7]}}, w_rd_word[7:0]};
         F3_H:    rdata = {{16{w_rd_word[15]}}, w_rd_word[15:0]};
         F3_BU:   rdata = {24'd0, w_rd_word[7:0]};
         F3_HU:   rdata = {16'd0, w_rd_word[15:0]};
         default: rdata = w_rd_word;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit for a single-port data memory without byte enables.
// Sub-word and misaligned stores use read-modify-write; word-straddling
// accesses are split into two word accesses.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int MEM_AW = 30
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   output logic        mem_oe,
   input  logic [31:0] mem_rd
);

   state_t              r_state;
   state_t              w_state_next;
   logic [MEM_AW-1:0]   r_w0;
   logic [1:0]          r_off;
   logic [2:0]          r_size;
   logic                r_we;
   logic [2:0]          r_funct3;
   logic [31:0]         r_wdata;
   logic [31:0]         r_buf0;
   logic [31:0]         r_buf1;

   logic                w_accept;
   logic                w_aligned_sw;
   logic                w_span;
   logic [MEM_AW-1:0]   w_w1;
   logic [31:0]         w_merge0;
   logic [31:0]         w_merge1;
   logic [31:0]         w_rdata;

   assign w_accept     = req_valid && (r_state == S_IDLE);
   assign w_aligned_sw = req_we && (req_funct3 == F3_W) && (req_addr[1:0] == 2'b00);
   assign w_span       = ({2'b00, r_off} + {1'b0, r_size}) > 4'd4;
   assign w_w1         = r_w0 + MEM_AW'(1);
   assign req_ready    = (r_state == S_IDLE);

   lsu_align u_align (
      .buf0   (r_buf0),
      .buf1   (r_buf1),
      .off    (r_off),
      .funct3 (r_funct3),
      .wdata  (r_wdata),
      .merge0 (w_merge0),
      .merge1 (w_merge1),
      .rdata  (w_rdata)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!f3_legal(req_we, req_funct3)) begin
                  w_state_next = S_ERR;
               end else if (w_aligned_sw) begin
                  w_state_next = S_WR0;
               end else begin
                  w_state_next = S_RD0;
               end
            end
         end
         S_RD0:   w_state_next = w_span ? S_RD1 : (r_we ? S_WR0 : S_RESP);
         S_RD1:   w_state_next = r_we ? S_WR0 : S_RESP;
         S_WR0:   w_state_next = w_span ? S_WR1 : S_RESP;
         S_WR1:   w_state_next = S_RESP;
         S_RESP:  w_state_next = S_IDLE;
         S_ERR:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Request capture; buffers are cleared on accept so stale data never leaks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w0     <= '0;
         r_off    <= '0;
         r_size   <= '0;
         r_we     <= 1'b0;
         r_funct3 <= '0;
         r_wdata  <= '0;
      end else if (w_accept) begin
         r_w0     <= req_addr[MEM_AW+1:2];
         r_off    <= req_addr[1:0];
         r_size   <= size_of(req_funct3);
         r_we     <= req_we;
         r_funct3 <= req_funct3;
         r_wdata  <= req_wdata;
      end
   end

   // Read buffers filled during the read phases.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf0 <= '0;
         r_buf1 <= '0;
      end else if (w_accept) begin
         r_buf0 <= '0;
         r_buf1 <= '0;
      end else if (r_state == S_RD0) begin
         r_buf0 <= mem_rd;
      end else if (r_state == S_RD1) begin
         r_buf1 <= mem_rd;
      end
   end

   // Memory and response outputs decoded from registered state only.
   always_comb begin
      mem_adr    = '0;
      mem_wd     = '0;
      mem_we     = 1'b0;
      mem_oe     = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      case (r_state)
         S_RD0: begin
            mem_adr = 32'(r_w0);
            mem_oe  = 1'b1;
         end
         S_RD1: begin
            mem_adr = 32'(w_w1);
            mem_oe  = 1'b1;
         end
         S_WR0: begin
            mem_adr = 32'(r_w0);
            mem_we  = 1'b1;
            mem_wd  = w_merge0;
         end
         S_WR1: begin
            mem_adr = 32'(w_w1);
            mem_we  = 1'b1;
            mem_wd  = w_merge1;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = r_we ? 32'd0 : w_rdata;
         end
         S_ERR: begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
